// File: rtl/operand_pair_loader.sv
// Collects two operand bytes from a valid/ready stream and holds them as a pair for the XOR/AND combiner.
// Define PAIR_COUNT_EN to build the saturating delivered-pair counter; otherwise pair_count is tied to zero.
module operand_pair_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic       busy,
    output logic [7:0] pair_count
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   byte_xfer;
    logic   pair_xfer;
    logic   load_a;
    logic   load_b;

    // The S_OUT term lets a new first byte enter in the same cycle the held pair leaves.
    assign in_ready  = !rst && !flush &&
                       (state == S_A || state == S_B || (state == S_OUT && pair_ready));
    assign byte_xfer = in_valid && in_ready;
    assign pair_xfer = pair_valid && pair_ready;
    assign busy      = (state != S_A);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        if (flush) begin
            state_next = S_A;
        end else begin
            case (state)
                S_A: begin
                    if (byte_xfer) begin
                        load_a     = 1'b1;
                        state_next = S_B;
                    end
                end
                S_B: begin
                    if (byte_xfer) begin
                        load_b     = 1'b1;
                        state_next = S_OUT;
                    end
                end
                S_OUT: begin
                    if (byte_xfer) begin
                        load_a     = 1'b1;
                        state_next = S_B;
                    end else if (pair_xfer) begin
                        state_next = S_A;
                    end
                end
                default: state_next = S_A;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_A;
            pair_valid <= 1'b0;
            op_a       <= 8'h00;
            op_b       <= 8'h00;
        end else begin
            state      <= state_next;
            pair_valid <= (state_next == S_OUT);
            if (load_a) op_a <= in_data;
            if (load_b) op_b <= in_data;
        end
    end

`ifdef PAIR_COUNT_EN
    logic [7:0] count_q;

    // A pair taken in the same cycle as flush still counts: it was handed off while valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'h00;
        end else if (pair_xfer && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign pair_count = count_q;
`else
    assign pair_count = 8'h00;
`endif

endmodule

// File: tb/tb_operand_pair_loader.sv
// Directed self-checking bench for operand_pair_loader; inputs change 1 time unit after the rising edge.
// Counter expectations follow PAIR_COUNT_EN when the bench is compiled with the same macro.
module tb_operand_pair_loader;

`ifdef PAIR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       pair_valid;
    logic       pair_ready;
    logic       busy;
    logic [7:0] pair_count;

    int total  = 0;
    int passed = 0;
    int npairs;

    operand_pair_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .busy       (busy),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected)
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = 8'h5A;
        in_valid   = 1'b1;
        flush      = 1'b0;
        pair_ready = 1'b1;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_pair_valid", pair_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", pair_count, 0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;

        // First pair 0x3C/0xA5 with the consumer always ready.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        #1;
        check("s1_in_ready", in_ready, 1);
        step();
        check("s1_op_a", op_a, 8'h3C);
        check("s1_busy_b", busy, 1);
        check("s1_pv_lo", pair_valid, 0);
        in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        #1;
        check("s1_pv_hi", pair_valid, 1);
        check("s1_op_a2", op_a, 8'h3C);
        check("s1_op_b", op_b, 8'hA5);
        step();
        check("s1_back_idle", busy, 0);
        check("s1_pv_drop", pair_valid, 0);
        check("s1_op_a_kept", op_a, 8'h3C);
        check("s1_op_b_kept", op_b, 8'hA5);

        // Pair held under back-pressure while a new byte waits.
        pair_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h10;
        step();
        in_data = 8'h20;
        step();
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s2_in_ready_lo", in_ready, 0);
            check("s2_pv_hold", pair_valid, 1);
            check("s2_op_a_hold", op_a, 8'h10);
            check("s2_op_b_hold", op_b, 8'h20);
            step();
        end
        pair_ready = 1'b1;
        #1;
        check("s2_in_ready_hi", in_ready, 1);
        step();
        check("s2_op_a_new", op_a, 8'h77);
        check("s2_busy", busy, 1);
        check("s2_pv_lo", pair_valid, 0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("s2_flush_idle", busy, 0);
        check("s2_flush_op_a", op_a, 8'h77);

        // Back-to-back stream 0x01..0x08: a pair every other cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i + 1);
            #1;
            if (i >= 2 && i % 2 == 0) begin
                check("s3_pv", pair_valid, 1);
                check("s3_op_a", op_a, 32'(i - 1));
                check("s3_op_b", op_b, 32'(i));
            end else begin
                check("s3_pv_gap", pair_valid, 0);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("s3_last_pv", pair_valid, 1);
        check("s3_last_a", op_a, 8'h07);
        check("s3_last_b", op_b, 8'h08);
        step();
        check("s3_idle", busy, 0);

        // Flush with a partial pair outstanding.
        in_valid = 1'b1;
        in_data  = 8'h11;
        step();
        flush   = 1'b1;
        in_data = 8'h99;
        #1;
        check("s4_in_ready_flush", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("s4_busy", busy, 0);
        check("s4_pv", pair_valid, 0);
        check("s4_op_a", op_a, 8'h11);
        check("s4_op_b", op_b, 8'h08);
        in_valid = 1'b1;
        in_data  = 8'h22;
        step();
        in_data = 8'h33;
        step();
        in_valid = 1'b0;
        #1;
        check("s4_pair_pv", pair_valid, 1);
        check("s4_pair_a", op_a, 8'h22);
        check("s4_pair_b", op_b, 8'h33);
        step();

        // Flush discards a held pair; flush together with pair_ready still delivers it.
        pair_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h44;
        step();
        in_data = 8'h55;
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("s4_discard_pv", pair_valid, 0);
        check("s4_discard_busy", busy, 0);
        check("s4_discard_op_b", op_b, 8'h55);
        in_valid = 1'b1;
        in_data  = 8'h66;
        step();
        in_data = 8'h77;
        step();
        in_valid   = 1'b0;
        pair_ready = 1'b1;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        check("s4_flush_pr_pv", pair_valid, 0);
        check("s4_count", pair_count, CNT_EN ? 8 : 0);

        // Asynchronous reset mid-pair, in S_B and then in S_OUT.
        pair_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hCC;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("s5_b_busy", busy, 0);
        check("s5_b_op_a", op_a, 0);
        step();
        rst     = 1'b0;
        in_data = 8'hAA;
        step();
        in_data = 8'hBB;
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("s5_out_pv", pair_valid, 0);
        check("s5_out_op_a", op_a, 0);
        check("s5_out_op_b", op_b, 0);
        check("s5_out_busy", busy, 0);
        check("s5_out_in_ready", in_ready, 0);
        check("s5_out_count", pair_count, 0);
        step();
        rst = 1'b0;

        // 300 pairs to reach counter saturation.
        npairs     = 0;
        pair_ready = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_data = 8'(i);
            if (pair_valid) npairs++;
            step();
        end
        in_valid = 1'b0;
        if (pair_valid) npairs++;
        step();
        check("s6_pairs", npairs, 300);
        check("s6_count", pair_count, CNT_EN ? 255 : 0);
        check("s6_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/operand_pair_loader.md
OPERAND_PAIR_LOADER -- requirements
Module: operand_pair_loader

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 in_data  input  8  operand byte stream from the pins.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 flush  input  1  synchronous abort of any partial or held pair.
REQ-008 op_a  output  8  first operand of the held pair, fed to the XOR/AND combiner.
REQ-009 op_b  output  8  second operand of the held pair, fed to the XOR/AND combiner.
REQ-010 pair_valid  output  1  op_a/op_b form a complete pair.
REQ-011 pair_ready  input  1  the downstream combiner takes the pair this cycle.
REQ-012 busy  output  1  high when state is not S_A.
REQ-013 pair_count  output  8  count of delivered pairs (see Configuration).

Function
REQ-014 A byte transfer SHALL occur when in_valid && in_ready; a pair transfer SHALL occur when pair_valid && pair_ready.
REQ-015 The FSM SHALL have states S_A (await first byte), S_B (await second byte) and S_OUT (pair held).
REQ-016 in_ready SHALL equal !flush && (state==S_A || state==S_B || (state==S_OUT && pair_ready)).
REQ-017 In S_A, a byte transfer SHALL load op_a and move to S_B.
REQ-018 In S_B, a byte transfer SHALL load op_b and move to S_OUT.
REQ-019 pair_valid SHALL be registered and equal (state==S_OUT); it rises 1 cycle after the second byte is accepted.
REQ-020 In S_OUT without a pair transfer, op_a, op_b and pair_valid SHALL hold stable.
REQ-021 In S_OUT, a pair transfer without a byte transfer SHALL move to S_A.
REQ-022 In S_OUT, a simultaneous pair transfer and byte transfer SHALL load the new byte into op_a and move to S_B, giving zero-bubble back-to-back operation.
REQ-023 op_a and op_b SHALL keep their last values after handoff until they are overwritten by a new byte.
REQ-024 flush SHALL take priority over all other events: state goes to S_A and pair_valid goes to 0 next cycle, no byte is accepted, op_a/op_b are unchanged, and any held pair is discarded without counting.
REQ-025 A pair transfer and flush in the same cycle SHALL count as delivered, because pair_ready was sampled while pair_valid was high.
REQ-026 Sustained throughput SHALL be 1 pair per 2 clocks.

Reset
REQ-027 Asserting rst SHALL immediately force state=S_A, op_a=0, op_b=0, pair_valid=0, busy=0 and pair_count=0, including mid-pair.
REQ-028 in_ready SHALL be 0 while rst is high, and inputs SHALL be ignored until the first clock edge after rst deasserts.

Configuration
REQ-029 With macro PAIR_COUNT_EN defined, pair_count SHALL increment by 1 on each pair transfer and saturate at 255; it is not cleared by flush.
REQ-030 With PAIR_COUNT_EN undefined, pair_count SHALL be tied to 8'h00, no counter logic is built, and all other behaviour is identical.

Verification
REQ-031 Reset, then bytes 0x3C and 0xA5 with pair_ready=1 -> op_a=0x3C, op_b=0xA5, pair_valid high 1 cycle after 0xA5 is accepted, then S_A.
REQ-032 Pair held with pair_ready=0 for 5 cycles, in_valid=1 with 0x77 -> in_ready=0, op_a/op_b/pair_valid stable; when pair_ready=1, 0x77 is loaded into op_a in the same cycle.
REQ-033 Continuous in_valid and pair_ready=1, bytes 0x01..0x08 -> 4 pairs (01,02),(03,04),(05,06),(07,08) delivered, one every 2 cycles.
REQ-034 Byte 0x11 accepted, then flush=1 with in_valid=1 -> no byte taken, state S_A, busy=0; the next bytes 0x22 and 0x33 form pair (0x22,0x33).
REQ-035 rst asserted in S_B or S_OUT -> all outputs 0 asynchronously, before the next clock edge.
REQ-036 With PAIR_COUNT_EN, 300 pair transfers -> pair_count=255; without the macro -> pair_count=0 throughout.
